// File: rtl/ysyx_040978_mdu_pkg.sv
// Shared definitions for the sequential RV64M multiply/divide unit.
// Optional word (*W) support is enabled with YSYX_040978_MDU_WORD_EN.
package ysyx_040978_mdu_pkg;

  // Default operand/result width.
  localparam int MDU_XLEN = 64;

  // in_op encoding: bit 3 = word, bit 2 = divide class, bits 1:0 = function.
  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd12;
  localparam logic [3:0] OP_DIVUW  = 4'd13;
  localparam logic [3:0] OP_REMW   = 4'd14;
  localparam logic [3:0] OP_REMUW  = 4'd15;

  // Function field values used by the result selection.
  localparam logic [1:0] FN_MUL   = 2'd0;
  localparam logic [1:0] FN_MULHU = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Width of an iteration counter that must hold the value xlen.
  function automatic int cnt_w(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/ysyx_040978_mdu_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply or restoring
// shift-subtract divide on unsigned magnitudes. Operands are pre-shifted
// so an n-iteration run leaves the result right-aligned.
module ysyx_040978_mdu_iter
  import ysyx_040978_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int CW   = cnt_w(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            is_div,
  input  logic [CW-1:0]   n,
  input  logic [XLEN-1:0] mag1,
  input  logic [XLEN-1:0] mag2,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  // acc_q: product (multiply) or remainder in the upper half (divide).
  // mq_q: multiplier bits / dividend bits, consumed from the MSB; for a
  // divide the quotient bits shift in at the LSB.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mq_q, mq_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              div_q, div_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN:0]     trial, diff;
  logic [CW-1:0]     shamt;

  // Load on start, otherwise perform one iteration while the counter runs.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    acc_d = acc_q;
    mq_d  = mq_q;
    dvs_d = dvs_q;
    div_d = div_q;
    cnt_d = cnt_q;
    shamt = CW'(XLEN) - n;
    trial = {acc_q[2*XLEN-1:XLEN], mq_q[XLEN-1]};
    diff  = trial - {1'b0, dvs_q};
    if (start) begin
      acc_d = '0;
      mq_d  = mag1 << shamt;
      dvs_d = mag2;
      div_d = is_div;
      cnt_d = n;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      mq_d  = {mq_q[XLEN-2:0], 1'b0};
      if (div_q) begin
        // Remainder stays below the divisor, so diff[XLEN] is a pure borrow.
        if (!diff[XLEN]) begin
          acc_d[2*XLEN-1:XLEN] = diff[XLEN-1:0];
          mq_d[0]              = 1'b1;
        end else begin
          acc_d[2*XLEN-1:XLEN] = trial[XLEN-1:0];
        end
      end else begin
        acc_d = {acc_q[2*XLEN-2:0], 1'b0}
              + {{XLEN{1'b0}}, (mq_q[XLEN-1] ? dvs_q : '0)};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      mq_q  <= '0;
      dvs_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so each flop sees the pre-edge value of the others.
      acc_q <= acc_d;
      mq_q  <= mq_d;
      dvs_q <= dvs_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign hi   = acc_q[2*XLEN-1:XLEN];
  assign lo   = div_q ? mq_q : acc_q[XLEN-1:0];

endmodule

// File: rtl/ysyx_040978_mdu_seq.sv
// Handshaked sequential RV64M multiply/divide unit with flush.
// Define YSYX_040978_MDU_WORD_EN to enable the 32-bit *W operations
// (XLEN must then be 64).
module ysyx_040978_mdu_seq
  import ysyx_040978_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CW = cnt_w(XLEN);
  localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};

  if (XLEN < 8 || (XLEN % 2) != 0) begin : g_bad_xlen
    $error("XLEN must be even and at least 8");
  end
`ifdef YSYX_040978_MDU_WORD_EN
  if (XLEN != 64) begin : g_bad_word_xlen
    $error("word operations require XLEN = 64");
  end
`endif

  state_e          state_q, state_d;
  logic            div_q, div_d;
  logic [1:0]      fn_q, fn_d;
  logic            neg1_q, neg1_d;
  logic            neg2_q, neg2_d;
  logic            spec_q, spec_d;
  logic [XLEN-1:0] spec_res_q, spec_res_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
`ifdef YSYX_040978_MDU_WORD_EN
  logic            word_q, word_d;
  logic            op_word;
`else
  logic            op_word_unused;
  assign op_word_unused = in_op[3];
`endif

  logic            op_div, sgn1, sgn2, neg1, neg2;
  logic [1:0]      op_fn;
  logic [XLEN-1:0] v1, v2, mag1, mag2, min_neg, spec_res;
  logic            div_zero, div_ovf, special;
  logic [CW-1:0]   it_n;
  logic            accept, start, fix_en;
  logic            it_done;
  logic [XLEN-1:0] it_hi, it_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem, fix_res;

  // Decode the request: signedness, extended operands, magnitudes, special cases.
  always_comb begin
    op_div  = in_op[2];
    op_fn   = in_op[1:0];
    v1      = in_src1;
    v2      = in_src2;
    min_neg = MIN_FULL;
    it_n    = CW'(XLEN);
`ifdef YSYX_040978_MDU_WORD_EN
    op_word = in_op[3];
    // Codes 9-11 behave as MULW.
    if (op_word && !op_div) op_fn = FN_MUL;
`endif
    sgn1 = op_div ? !op_fn[0] : (op_fn != FN_MULHU);
    sgn2 = op_div ? !op_fn[0] : !op_fn[1];
`ifdef YSYX_040978_MDU_WORD_EN
    if (op_word) begin
      v1      = {{(XLEN-32){sgn1 & in_src1[31]}}, in_src1[31:0]};
      v2      = {{(XLEN-32){sgn2 & in_src2[31]}}, in_src2[31:0]};
      min_neg = {{(XLEN-31){1'b1}}, 31'd0};
      it_n    = CW'(32);
    end
`endif
    neg1     = sgn1 & v1[XLEN-1];
    neg2     = sgn2 & v2[XLEN-1];
    mag1     = neg1 ? -v1 : v1;
    mag2     = neg2 ? -v2 : v2;
    div_zero = op_div && (v2 == '0);
    div_ovf  = op_div && sgn1 && (v1 == min_neg) && (v2 == '1);
    special  = div_zero || div_ovf;
    spec_res = '0;
    if (div_zero)     spec_res = op_fn[1] ? v1 : '1;
    else if (div_ovf) spec_res = op_fn[1] ? '0 : v1;
  end

  // Next state: flush dominates, then the normal IDLE/CALC/FIX/DONE flow.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_FIX : ST_CALC;
      ST_CALC: if (it_done) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // FSM outputs and handshake qualifiers.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    fix_en    = (state_q == ST_FIX);
    accept    = in_ready && in_valid && !flush;
    start     = accept && !special;
  end

  // Capture the decoded request on accept; hold it otherwise.
  always_comb begin
    div_d      = div_q;
    fn_d       = fn_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
`ifdef YSYX_040978_MDU_WORD_EN
    word_d     = word_q;
`endif
    if (accept) begin
      div_d      = op_div;
      fn_d       = op_fn;
      neg1_d     = neg1;
      neg2_d     = neg2;
      spec_d     = special;
      spec_res_d = spec_res;
`ifdef YSYX_040978_MDU_WORD_EN
      word_d     = op_word;
`endif
    end
  end

  // FIX stage: apply signs, pick the result half, sign-extend word results.
  always_comb begin
    prod = {it_hi, it_lo};
    if (neg1_q ^ neg2_q) prod = -prod;
    quo = (neg1_q ^ neg2_q) ? -it_lo : it_lo;
    rem = neg1_q ? -it_hi : it_hi;
    if (spec_q)              fix_res = spec_res_q;
    else if (div_q)          fix_res = fn_q[1] ? rem : quo;
    else if (fn_q == FN_MUL) fix_res = prod[XLEN-1:0];
    else                     fix_res = prod[2*XLEN-1:XLEN];
`ifdef YSYX_040978_MDU_WORD_EN
    if (word_q) fix_res = {{(XLEN-32){fix_res[31]}}, fix_res[31:0]};
`endif
    out_result_d = (fix_en && !flush) ? fix_res : out_result_q;
  end

  // Control and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      div_q        <= 1'b0;
      fn_q         <= 2'd0;
      neg1_q       <= 1'b0;
      neg2_q       <= 1'b0;
      spec_q       <= 1'b0;
      spec_res_q   <= '0;
      out_result_q <= '0;
`ifdef YSYX_040978_MDU_WORD_EN
      word_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      fn_q         <= fn_d;
      neg1_q       <= neg1_d;
      neg2_q       <= neg2_d;
      spec_q       <= spec_d;
      spec_res_q   <= spec_res_d;
      out_result_q <= out_result_d;
`ifdef YSYX_040978_MDU_WORD_EN
      word_q       <= word_d;
`endif
    end
  end

  assign out_result = out_result_q;

  ysyx_040978_mdu_iter #(.XLEN(XLEN), .CW(CW)) u_iter (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .is_div (op_div),
    .n      (it_n),
    .mag1   (mag1),
    .mag2   (mag2),
    .done   (it_done),
    .hi     (it_hi),
    .lo     (it_lo)
  );

endmodule
